// File: rtl/lfsr_crypt_seq.sv
// Run sequencer for the encryption datapath: reads preamble length, taps and seed from data memory,
// loads the external 6-bit LFSR, then writes the scrambled pad preamble followed by the scrambled message.
module lfsr_crypt_seq #(
    parameter int         MSG_LEN  = 50,
    parameter int         SRC_BASE = 0,
    parameter int         CFG_BASE = 61,
    parameter int         DST_BASE = 64,
    parameter int         PRE_MIN  = 7,
    parameter int         PRE_MAX  = 12,
    parameter logic [7:0] PAD_CHAR = 8'h5F
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] raddr,
    input  logic [7:0] data_out,
    output logic [7:0] waddr,
    output logic [7:0] data_in,
    output logic       write_en,
    output logic       lfsr_en,
    output logic       lfsr_load,
    output logic [5:0] taps,
    output logic [5:0] seed,
    input  logic [5:0] lfsr_state
);

    localparam logic [7:0] SRC_ADDR  = 8'(SRC_BASE);
    localparam logic [7:0] DST_ADDR  = 8'(DST_BASE);
    localparam logic [7:0] CFG_PRE   = 8'(CFG_BASE);
    localparam logic [7:0] CFG_TAPS  = 8'(CFG_BASE + 1);
    localparam logic [7:0] CFG_SEED  = 8'(CFG_BASE + 2);
    localparam logic [7:0] PRE_LO    = 8'(PRE_MIN);
    localparam logic [7:0] PRE_HI    = 8'(PRE_MAX);
    localparam logic [7:0] MSG_LAST  = 8'(MSG_LEN - 1);

    generate
        if (DST_BASE + PRE_MAX + MSG_LEN > 256) begin : g_bad_params
            $error("lfsr_crypt_seq: DST_BASE+PRE_MAX+MSG_LEN exceeds the 8-bit address space");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, LD_PRE, LD_TAPS, LD_SEED, SEED, PRE, MSG, DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] p_reg, p_next;
    logic [7:0] k_reg, k_next;
    logic [5:0] taps_reg, taps_next;
    logic [5:0] seed_reg, seed_next;
    logic [7:0] raddr_reg, waddr_reg, data_in_reg;
    logic [7:0] pre_clamped;

    assign taps = taps_reg;
    assign seed = seed_reg;

    always_comb begin
        if (data_out < PRE_LO)
            pre_clamped = PRE_LO;
        else if (data_out > PRE_HI)
            pre_clamped = PRE_HI;
        else
            pre_clamped = data_out;
    end

    // Outputs are decoded from the state so that an asynchronous reset drops the enables immediately;
    // addresses and write data fall back to their last driven value outside the active states.
    always_comb begin
        state_next = state_reg;
        p_next     = p_reg;
        k_next     = k_reg;
        taps_next  = taps_reg;
        seed_next  = seed_reg;
        raddr      = raddr_reg;
        waddr      = waddr_reg;
        data_in    = data_in_reg;
        write_en   = 1'b0;
        lfsr_en    = 1'b0;
        lfsr_load  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                done = (state_reg == DONE);
                if (start) begin
                    state_next = LD_PRE;
                    k_next     = 8'd0;
                end
            end
            LD_PRE: begin
                busy       = 1'b1;
                raddr      = CFG_PRE;
                p_next     = pre_clamped;
                state_next = LD_TAPS;
            end
            LD_TAPS: begin
                busy       = 1'b1;
                raddr      = CFG_TAPS;
                taps_next  = data_out[5:0];
                state_next = LD_SEED;
            end
            LD_SEED: begin
                busy       = 1'b1;
                raddr      = CFG_SEED;
                seed_next  = (data_out[5:0] == 6'd0) ? 6'h01 : data_out[5:0];
                state_next = SEED;
            end
            SEED: begin
                busy       = 1'b1;
                lfsr_load  = 1'b1;
                state_next = PRE;
            end
            PRE: begin
                busy     = 1'b1;
                write_en = 1'b1;
                lfsr_en  = 1'b1;
                waddr    = DST_ADDR + k_reg;
                data_in  = PAD_CHAR ^ {2'b00, lfsr_state};
                if (k_reg == p_reg - 8'd1) begin
                    k_next     = 8'd0;
                    state_next = MSG;
                end else begin
                    k_next = k_reg + 8'd1;
                end
            end
            MSG: begin
                busy     = 1'b1;
                write_en = 1'b1;
                lfsr_en  = 1'b1;
                raddr    = SRC_ADDR + k_reg;
                waddr    = DST_ADDR + p_reg + k_reg;
                data_in  = data_out ^ {2'b00, lfsr_state};
                if (k_reg == MSG_LAST)
                    state_next = DONE;
                else
                    k_next = k_reg + 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_reg   <= IDLE;
            p_reg       <= 8'd0;
            k_reg       <= 8'd0;
            taps_reg    <= 6'd0;
            seed_reg    <= 6'd0;
            raddr_reg   <= 8'd0;
            waddr_reg   <= 8'd0;
            data_in_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            p_reg       <= p_next;
            k_reg       <= k_next;
            taps_reg    <= taps_next;
            seed_reg    <= seed_next;
            raddr_reg   <= raddr;
            waddr_reg   <= waddr;
            data_in_reg <= data_in;
        end
    end

endmodule
